pcie_link_stat_monitor: RTL and testbench

Upstream feeder for the PCIe debug UART transmitter, in the XDMA axi_aclk domain. Synchronises and debounces the raw PCIe link-up indication into a clean `link_up` level. Keeps a set of saturating statistics counters. Rotates through them, presenting one tagged 32-bit word at a time on `counter_val`, so each periodic UART line shows a different statistic.

---
 rtl/pcie_link_stat_monitor.sv | 178 +++++++++++++++++
 tb/tb_pcie_link_stat_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_link_stat_monitor.sv
// rtl/pcie_link_stat_monitor.sv - PCIe link debounce and rotating statistics feeder for the debug UART
//
// Purpose:
//   Synchronises and debounces the raw XDMA link-up indication. Keeps saturating
//   28-bit statistics counters and rotates through them, presenting one tagged
//   word {tag[3:0], value[27:0]} at a time on counter_val.
//
// Optional feature macro: LINK_UPTIME_EN
//   When defined, adds slot 4 (tag 0x5): link uptime in milliseconds for the
//   current session.
//
// Ports:
//   clk          in   axi_aclk
//   rst_n        in   asynchronous active-low reset
//   lnk_up_raw   in   raw user_lnk_up, asynchronous to clk
//   rx_beat      in   one pulse per accepted RX AXIS beat
//   tx_beat      in   one pulse per accepted TX AXIS beat
//   err_pulse    in   one pulse per detected error event
//   clr_stats    in   synchronous clear of all statistics
//   link_up      out  debounced link status (registered)
//   counter_val  out  {tag, value} of the selected statistic (registered)

module pcie_link_stat_monitor #(
  parameter int unsigned CLK_FREQ        = 250_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned DWELL_CYCLES    = 250_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lnk_up_raw,
  input  logic        rx_beat,
  input  logic        tx_beat,
  input  logic        err_pulse,
  input  logic        clr_stats,
  output logic        link_up,
  output logic [31:0] counter_val
);

`ifdef LINK_UPTIME_EN
  localparam int unsigned NUM_SLOTS = 5;
`else
  localparam int unsigned NUM_SLOTS = 4;
`endif
  localparam logic [2:0]  LAST_SLOT = 3'(NUM_SLOTS - 1);
  localparam logic [27:0] SAT_MAX   = 28'hFFF_FFFF;

  function automatic logic [27:0] sat_inc(input logic [27:0] v);
    return (v == SAT_MAX) ? v : v + 28'd1;
  endfunction

  // Synchroniser and debounce
  logic        lnk_s1;
  logic        lnk_s;
  logic [31:0] db_cnt;
  logic        db_hit;
  logic        link_rise;

  // The debounced level flips only after lnk_s has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles.
  assign db_hit    = (lnk_s != link_up) && (db_cnt == 32'(DEBOUNCE_CYCLES - 1));
  assign link_rise = db_hit && lnk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lnk_s1  <= 1'b0;
      lnk_s   <= 1'b0;
      db_cnt  <= '0;
      link_up <= 1'b0;
    end else begin
      lnk_s1 <= lnk_up_raw;
      lnk_s  <= lnk_s1;
      if (lnk_s == link_up) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        link_up <= lnk_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  // Statistics counters; clear has priority over a coincident event
  logic [27:0] flap_cnt;
  logic [27:0] rx_cnt;
  logic [27:0] tx_cnt;
  logic [27:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flap_cnt <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      err_cnt  <= '0;
    end else if (clr_stats) begin
      flap_cnt <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      err_cnt  <= '0;
    end else begin
      if (link_rise) flap_cnt <= sat_inc(flap_cnt);
      if (rx_beat)   rx_cnt   <= sat_inc(rx_cnt);
      if (tx_beat)   tx_cnt   <= sat_inc(tx_cnt);
      if (err_pulse) err_cnt  <= sat_inc(err_cnt);
    end
  end

`ifdef LINK_UPTIME_EN
  // Millisecond uptime of the current link session
  localparam int unsigned PS_LAST = CLK_FREQ / 1000 - 1;
  logic [31:0] ps_cnt;
  logic [27:0] up_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      up_cnt <= '0;
    end else if (clr_stats || link_rise) begin
      // A new session starts from zero; link_up is still 0 on this edge so
      // the prescaler is already idle.
      ps_cnt <= '0;
      up_cnt <= '0;
    end else if (!link_up) begin
      // Hold the last session's uptime while the link is down.
      ps_cnt <= '0;
    end else if (ps_cnt == 32'(PS_LAST)) begin
      ps_cnt <= '0;
      up_cnt <= sat_inc(up_cnt);
    end else begin
      ps_cnt <= ps_cnt + 32'd1;
    end
  end
`else
  logic unused_clk_freq;
  assign unused_clk_freq = ^CLK_FREQ;
`endif

  // Rotation through the implemented slots
  logic [31:0] dwell_cnt;
  logic [2:0]  sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      sel       <= '0;
    end else if (dwell_cnt == 32'(DWELL_CYCLES - 1)) begin
      dwell_cnt <= '0;
      sel       <= (sel == LAST_SLOT) ? 3'd0 : sel + 3'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 32'd1;
    end
  end

  // Output mux, registered every cycle so it follows live counter values
  logic [31:0] sel_val;

  always_comb begin
    sel_val = {4'h1, flap_cnt};
    case (sel)
      3'd1:    sel_val = {4'h2, rx_cnt};
      3'd2:    sel_val = {4'h3, tx_cnt};
      3'd3:    sel_val = {4'h4, err_cnt};
`ifdef LINK_UPTIME_EN
      3'd4:    sel_val = {4'h5, up_cnt};
`endif
      default: sel_val = {4'h1, flap_cnt};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_val <= 32'h1000_0000;
    end else begin
      counter_val <= sel_val;
    end
  end

endmodule

// File: tb/tb_pcie_link_stat_monitor.sv
// tb/tb_pcie_link_stat_monitor.sv - directed self-checking bench for pcie_link_stat_monitor

module tb_pcie_link_stat_monitor;

`ifdef LINK_UPTIME_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lnk_up_raw;
  logic        rx_beat;
  logic        tx_beat;
  logic        err_pulse;
  logic        clr_stats;
  logic        link_up;
  logic [31:0] counter_val;

  int tests_run = 0;
  int tests_failed = 0;

  pcie_link_stat_monitor #(
    .CLK_FREQ        (4000),
    .DEBOUNCE_CYCLES (4),
    .DWELL_CYCLES    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lnk_up_raw  (lnk_up_raw),
    .rx_beat     (rx_beat),
    .tx_beat     (tx_beat),
    .err_pulse   (err_pulse),
    .clr_stats   (clr_stats),
    .link_up     (link_up),
    .counter_val (counter_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a fresh appearance of the given tag on counter_val.
  task automatic wait_tag(input logic [3:0] t);
    int n;
    n = 0;
    while (counter_val[31:28] == t && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (counter_val[31:28] != t && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (counter_val[31:28] != t) check("wait_tag", {28'd0, counter_val[31:28]}, {28'd0, t});
  endtask

  function automatic logic [3:0] exp_tag(input int k);
    return 4'(1 + ((k - 1) / 8) % NS);
  endfunction

  initial begin
    rst_n      = 1'b0;
    lnk_up_raw = 1'b0;
    rx_beat    = 1'b0;
    tx_beat    = 1'b0;
    err_pulse  = 1'b0;
    clr_stats  = 1'b0;
    tick(2);
    check("reset_link_up", {31'd0, link_up}, 32'd0);
    check("reset_counter_val", counter_val, 32'h1000_0000);

    // Rotation from reset release: k = posedges since release
    rst_n = 1'b1;
    tick(8);
    check("rot_k8", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(8)});
    tick(1);
    check("rot_k9", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(9)});
    tick(8);
    check("rot_k17", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(17)});
    tick(8);
    check("rot_k25", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(25)});
    tick(8);
    check("rot_k33", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(33)});
    tick(8);
    check("rot_k41", {28'd0, counter_val[31:28]}, {28'd0, exp_tag(41)});

    // Debounce: clean step takes effect on the 6th edge
    lnk_up_raw = 1'b1;
    tick(5);
    check("db_step_edge5", {31'd0, link_up}, 32'd0);
    tick(1);
    check("db_step_edge6", {31'd0, link_up}, 32'd1);
    lnk_up_raw = 1'b0;
    tick(1);
    lnk_up_raw = 1'b1;
    tick(10);
    check("db_glitch1", {31'd0, link_up}, 32'd1);
    lnk_up_raw = 1'b0;
    tick(3);
    lnk_up_raw = 1'b1;
    tick(10);
    check("db_glitch3", {31'd0, link_up}, 32'd1);
    wait_tag(4'h1);
    check("flap_one", counter_val, 32'h1000_0001);

    // RX count and one-cycle latency
    rx_beat = 1'b1;
    tick(9);
    rx_beat = 1'b0;
    wait_tag(4'h2);
    check("rx_nine", counter_val, 32'h2000_0009);
    rx_beat = 1'b1;
    tick(1);
    rx_beat = 1'b0;
    check("rx_latency", counter_val, 32'h2000_0009);
    tick(1);
    check("rx_ten", counter_val, 32'h2000_000A);

    tx_beat = 1'b1;
    tick(3);
    tx_beat = 1'b0;
    wait_tag(4'h3);
    check("tx_three", counter_val, 32'h3000_0003);

    // ERR saturation and clear-beats-increment
    wait_tag(4'h4);
    force dut.err_cnt = 28'hFFF_FFFE;
    #1;
    release dut.err_cnt;
    err_pulse = 1'b1;
    tick(3);
    err_pulse = 1'b0;
    tick(1);
    check("err_saturate", counter_val, 32'h4FFF_FFFF);
    err_pulse = 1'b1;
    clr_stats = 1'b1;
    tick(1);
    err_pulse = 1'b0;
    clr_stats = 1'b0;
    tick(1);
    check("err_clear_wins", counter_val, 32'h4000_0000);
    wait_tag(4'h2);
    check("rx_cleared", counter_val, 32'h2000_0000);

`ifdef LINK_UPTIME_EN
    // Uptime: link_up high for exactly 20 cycles -> 5 ms at 4 cycles/ms
    begin
      int n;
      lnk_up_raw = 1'b0;
      tick(10);
      lnk_up_raw = 1'b1;
      n = 0;
      while (!link_up && n < 20) begin
        tick(1);
        n++;
      end
      check("up_link_rise", {31'd0, link_up}, 32'd1);
      tick(14);
      lnk_up_raw = 1'b0;
      tick(10);
      check("up_link_drop", {31'd0, link_up}, 32'd0);
      wait_tag(4'h5);
      check("uptime_five", counter_val, 32'h5000_0005);
      wait_tag(4'h5);
      check("uptime_hold", counter_val, 32'h5000_0005);
      lnk_up_raw = 1'b1;
      tick(7);
      check("uptime_relink_clear", counter_val, 32'h5000_0000);
    end
`endif

    // Asynchronous reset mid-run with slot 2 selected
    wait_tag(4'h3);
    #2;
    rst_n = 1'b0;
    lnk_up_raw = 1'b0;
    #1;
    check("arst_link_up", {31'd0, link_up}, 32'd0);
    check("arst_counter_val", counter_val, 32'h1000_0000);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("arst_flap_zero", counter_val, 32'h1000_0000);
    tick(7);
    check("arst_rot_k8", {28'd0, counter_val[31:28]}, 32'd1);
    tick(1);
    check("arst_rot_k9", {28'd0, counter_val[31:28]}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
